iter_divider: RTL

//  Multi-cycle restoring divider for the datapath: 16-bit signed/unsigned quotient and remainder.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 27 ++
 rtl/iter_divider.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] DIV_SMIN     = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic [WIDTH-1:0] quo_next_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // The partial remainder stays below the divisor, so after a failed trial it still fits WIDTH bits.
  always_comb begin
    shifted    = {rem_i, quo_i[WIDTH-1]};
    trial      = shifted - {1'b0, dvsr_i};
    fits       = (shifted >= {1'b0, dvsr_i});
    rem_next_o = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next_o = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned restoring divider: accept, WIDTH iterations, sign fix-up, done pulse.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             isSigned_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             divZero_o,
  output logic             ovfl_o
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH-1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             signQuo_q, signQuo_d;
  logic             signRem_q, signRem_d;
  logic             zeroPend_q, zeroPend_d;
  logic             ovflPend_q, ovflPend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divZero_q, divZero_d;
  logic             ovfl_q, ovfl_d;
  logic             done_q, done_d;

  logic             negDvd, negDvs;
  logic [WIDTH-1:0] stepRem, stepQuo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i      (rem_q),
    .quo_i      (quo_q),
    .dvsr_i     (dvsr_q),
    .rem_next_o (stepRem),
    .quo_next_o (stepQuo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    signQuo_d   = signQuo_q;
    signRem_d   = signRem_q;
    zeroPend_d  = zeroPend_q;
    ovflPend_d  = ovflPend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divZero_d   = divZero_q;
    ovfl_d      = ovfl_q;
    done_d      = 1'b0;
    negDvd      = isSigned_i & dividend_i[WIDTH-1];
    negDvs      = isSigned_i & divisor_i[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // Magnitudes are plain unsigned values, so -SMIN = SMIN is still exact.
          quo_d       = negDvd ? -dividend_i : dividend_i;
          dvsr_d      = negDvs ? -divisor_i : divisor_i;
          rem_d       = '0;
          cnt_d       = '0;
          signQuo_d   = negDvd ^ negDvs;
          signRem_d   = negDvd;
          zeroPend_d  = (divisor_i == '0);
          ovflPend_d  = isSigned_i & (dividend_i == SMIN) & (divisor_i == ALL_ONES);
          quotient_d  = '0;
          remainder_d = '0;
          divZero_d   = 1'b0;
          ovfl_d      = 1'b0;
          state_d     = RUN;
          if (divisor_i == '0) begin
            quo_d     = ALL_ONES;
            rem_d     = dividend_i;
            signQuo_d = 1'b0;
            signRem_d = 1'b0;
            state_d   = FIX;
          end
        end
      end
      RUN: begin
        rem_d = stepRem;
        quo_d = stepQuo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) state_d = FIX;
      end
      FIX: begin
        quotient_d  = signQuo_q ? -quo_q : quo_q;
        remainder_d = signRem_q ? -rem_q : rem_q;
        divZero_d   = zeroPend_q;
        ovfl_d      = ovflPend_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      signQuo_q   <= 1'b0;
      signRem_q   <= 1'b0;
      zeroPend_q  <= 1'b0;
      ovflPend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
      ovfl_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      signQuo_q   <= signQuo_d;
      signRem_q   <= signRem_d;
      zeroPend_q  <= zeroPend_d;
      ovflPend_q  <= ovflPend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divZero_q   <= divZero_d;
      ovfl_q      <= ovfl_d;
      done_q      <= done_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign divZero_o   = divZero_q;
  assign ovfl_o      = ovfl_q;

endmodule
